// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq shared constants: HI/LO opcodes,
// ALU function codes and FSM encoding.
package muldiv_seq_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MTHI  = 2'b10;
  localparam logic [1:0] MD_MTLO  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_seq.sv
// Sequential HI/LO unit: shift-add MULTU, restoring DIVU,
// MTHI/MTLO. All adds/subtracts go through the shared ALU.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  logic [1:0]      state;
  logic [XLEN-1:0] opnd;
  logic [4:0]      cnt;
  logic            cur_op;
  logic            mt_done;

  logic            issue;
  logic            is_run;
  logic [XLEN-1:0] rem_sh;
  logic            rem_msb;
  logic            take;
  logic            carry;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] hi_nx;
  logic [XLEN-1:0] lo_nx;

  assign is_run = (state == ST_RUN);
  assign issue  = start & (state == ST_IDLE);
  assign busy   = is_run | (state == ST_DONE);
  assign done   = (state == ST_DONE) | mt_done;

  // Divide view: partial remainder shifted left by one bit.
  always_comb begin
    rem_sh  = {hi[XLEN-2:0], lo[XLEN-1]};
    rem_msb = hi[XLEN-1];
  end

  // Drive the shared ALU only while iterating.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    unique case (1'b1)
      is_run && cur_op == OP_MUL: begin
        alu_a    = hi;
        alu_b    = opnd;
        alu_ctrl = ALU_ADD;
      end
      is_run && cur_op == OP_DIV: begin
        alu_a    = rem_sh;
        alu_b    = opnd;
        alu_ctrl = ALU_SUB;
      end
      default: begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    sum   = hi;
    carry = 1'b0;
    take  = 1'b0;
    hi_nx = hi;
    lo_nx = lo;
    if (cur_op == OP_MUL) begin
      if (lo[0]) begin
        sum   = alu_result;
        carry = (alu_result < hi);
      end
      hi_nx = {carry, sum[XLEN-1:1]};
      lo_nx = {sum[0], lo[XLEN-1:1]};
    end else begin
      // The 33rd remainder bit forces a subtract.
      take  = rem_msb | (rem_sh >= opnd);
      hi_nx = take ? alu_result : rem_sh;
      lo_nx = {lo[XLEN-2:0], take};
    end
  end

  // FSM plus HI/LO/operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      cur_op   <= OP_MUL;
      div_zero <= 1'b0;
      mt_done  <= 1'b0;
    end else begin
      mt_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (issue) begin
            unique case (op)
              MD_MULTU: begin
                hi       <= '0;
                lo       <= rt;
                opnd     <= rs;
                cnt      <= '0;
                cur_op   <= OP_MUL;
                div_zero <= 1'b0;
                state    <= ST_RUN;
              end
              MD_DIVU: begin
                hi       <= '0;
                lo       <= rs;
                opnd     <= rt;
                cnt      <= '0;
                cur_op   <= OP_DIV;
                div_zero <= (rt == '0);
                state    <= ST_RUN;
              end
              MD_MTHI: begin
                hi      <= rs;
                mt_done <= 1'b1;
              end
              MD_MTLO: begin
                lo      <= rs;
                mt_done <= 1'b1;
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end
        ST_RUN: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq; the bench
// plays the shared ALU combinationally.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  int checks;
  int failures;

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .rs(rs),
    .rt(rt),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_ctrl(alu_ctrl),
    .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (alu_ctrl == 4'b0110) alu_result = alu_a - alu_b;
    else alu_result = alu_a + alu_b;
  end

  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    rs = '0;
    rt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000",
               {busy, done, div_zero});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      failures++;
      $display("FAIL reset_hilo got=%h want=0", {hi, lo});
    end
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 ||
        alu_ctrl !== 4'b0010) begin
      failures++;
      $display("FAIL reset_alu got=%h/%h/%b want=0/0/0010",
               alu_a, alu_b, alu_ctrl);
    end
  endtask

  task automatic test_multu_timing;
    logic eb;
    logic ed;
    issue(2'b00, 32'd7, 32'd6);
    for (int m = 1; m <= 34; m++) begin
      @(negedge clk);
      eb = (m <= 33);
      ed = (m == 33);
      checks++;
      if (busy !== eb || done !== ed) begin
        failures++;
        $display("FAIL mul7x6_c%0d busy/done got=%b%b want=%b%b",
                 m, busy, done, eb, ed);
      end
      if (m == 33) begin
        checks++;
        if (hi !== 32'h0 || lo !== 32'h2A) begin
          failures++;
          $display("FAIL mul7x6 got=%h_%h want=0_2a", hi, lo);
        end
      end
    end
  endtask

  task automatic test_multu_max;
    logic [127:0] ex;
    logic [63:0]  mask;
    logic [31:0]  a;
    logic [31:0]  b;
    int k;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    issue(2'b00, a, b);
    for (int m = 1; m <= 33; m++) begin
      @(negedge clk);
      k = m - 1;
      mask = (64'd1 << k) - 64'd1;
      ex = (128'(a) * 128'(64'(b) & mask)) << (32 - k);
      ex = ex | 128'(64'(b) >> k);
      checks++;
      if ({hi, lo} !== ex[63:0]) begin
        failures++;
        $display("FAIL mulmax_k%0d got=%h want=%h",
                 k, {hi, lo}, ex[63:0]);
      end
      if (m <= 32) begin
        checks++;
        if (alu_ctrl !== 4'b0010) begin
          failures++;
          $display("FAIL mulmax_ctrl%0d got=%b want=0010",
                   k, alu_ctrl);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || {hi, lo} !== 64'hFFFFFFFE_00000001) begin
      failures++;
      $display("FAIL mulmax_final got=%b %h want=1 fffffffe00000001",
               done, {hi, lo});
    end
  endtask

  task automatic test_divu;
    int lat;
    issue(2'b01, 32'd100, 32'd7);
    @(negedge clk);
    checks++;
    if (alu_ctrl !== 4'b0110 || alu_a !== 32'h0 ||
        alu_b !== 32'd7) begin
      failures++;
      $display("FAIL div_alu got=%b/%h/%h want=0110/0/7",
               alu_ctrl, alu_a, alu_b);
    end
    wait_done(lat);
    checks++;
    if (lat + 1 !== 33) begin
      failures++;
      $display("FAIL div_lat got=%0d want=33", lat + 1);
    end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL div100_7 got=q%0d r%0d z%b want=q14 r2 z0",
               lo, hi, div_zero);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(2'b01, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat);
    checks++;
    if (lat !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h0) begin
      failures++;
      $display("FAIL divmax got=lat%0d %h_%h want=lat33 0_ffffffff",
               lat, hi, lo);
    end
    issue(2'b00, 32'd1000, 32'd1000);
    wait_done(lat);
    checks++;
    if (lat !== 33 || hi !== 32'h0 || lo !== 32'd1000000) begin
      failures++;
      $display("FAIL b2b_mul got=lat%0d %h_%h want=lat33 0_000f4240",
               lat, hi, lo);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    issue(2'b01, 32'h8000_0000, 32'h0);
    wait_done(lat);
    checks++;
    if (lat !== 33 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL divz_flag got=lat%0d z%b want=lat33 z1",
               lat, div_zero);
    end
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h8000_0000) begin
      failures++;
      $display("FAIL divz_val got=%h_%h want=80000000_ffffffff",
               hi, lo);
    end
    issue(2'b11, 32'd55, 32'h0);
    @(negedge clk);
    checks++;
    if (lo !== 32'd55 || done !== 1'b1 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL mtlo got=lo%h d%b z%b want=lo37 d1 z1",
               lo, done, div_zero);
    end
    issue(2'b00, 32'd3, 32'd5);
    @(negedge clk);
    checks++;
    if (div_zero !== 1'b0) begin
      failures++;
      $display("FAIL divz_clear got=%b want=0", div_zero);
    end
    wait_done(lat);
    checks++;
    if (lo !== 32'd15 || hi !== 32'd0) begin
      failures++;
      $display("FAIL mul3x5 got=%h_%h want=0_f", hi, lo);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    issue(2'b00, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rstrun_flags got=%b%b want=00", busy, done);
    end
    checks++;
    if ({hi, lo} !== 64'h0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL rstrun_hilo got=%h z%b want=0 z0",
               {hi, lo}, div_zero);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rstrun_quiet got=%0d want=0", seen);
    end
  endtask

  task automatic test_mthi_busy;
    int lat;
    issue(2'b10, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    checks++;
    if (hi !== 32'hDEAD_BEEF || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi got=%h d%b b%b want=deadbeef d1 b0",
               hi, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi_pulse got=%b%b want=00", done, busy);
    end
    issue(2'b01, 32'd1000, 32'd10);
    repeat (4) @(negedge clk);
    issue(2'b11, 32'h1234_5678, 32'h0);
    wait_done(lat);
    checks++;
    if (lat !== 28 || lo !== 32'd100 || hi !== 32'd0) begin
      failures++;
      $display("FAIL busy_ign got=lat%0d %h_%h want=lat28 0_64",
               lat, hi, lo);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'd100) begin
      failures++;
      $display("FAIL busy_ign_after got=b%b d%b lo%h want=0 0 64",
               busy, done, lo);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_multu_timing();
    test_multu_max();
    test_divu();
    test_back_to_back();
    test_div_zero();
    test_reset_mid_run();
    test_mthi_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle HI/LO unit for MULTU, DIVU, MTHI and MTLO. It owns the HI and LO registers.
- It does no 32-bit add or subtract itself. It drives the shared 32-bit ALU through the alu_a, alu_b and alu_ctrl ports and consumes alu_result, one iteration per cycle.
- Sits in EX beside the main ALU path. The hazard unit stalls on busy; MFHI/MFLO read hi and lo directly.

Parameters:
- XLEN, 32, operand and register width. Only 32 is supported.
- ITER, 32, RUN iterations per MULTU or DIVU.

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- start  input  1  Issue request. Sampled only while busy=0.
- op  input  2  Operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
- rs  input  32  Multiplicand, dividend, or MTHI/MTLO source.
- rt  input  32  Multiplier or divisor.
- busy  output  1  High in states RUN and DONE.
- done  output  1  One-cycle pulse when the result is valid.
- div_zero  output  1  Registered flag: the last DIVU had rt=0.
- hi  output  32  HI register.
- lo  output  32  LO register.
- alu_a  output  32  ALU operand A (combinational from state).
- alu_b  output  32  ALU operand B.
- alu_ctrl  output  4  ALU function code: 0010 ADD, 0110 SUB.
- alu_result  input  32  Combinational ALU result, same cycle.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-RUN): state=IDLE, hi=0, lo=0, opnd=0, cnt=0, div_zero=0. Next cycle busy=0, done=0.
- States: IDLE, RUN, DONE.
  - IDLE to RUN on start with op=MULTU/DIVU.
  - RUN to DONE when cnt reaches ITER-1.
  - DONE to IDLE unconditionally.
- Internal registers: opnd (32-bit multiplicand or divisor), cnt (5 bits), cur_op (1 bit).
- MTHI/MTLO: a start in IDLE writes hi=rs or lo=rs at that edge. The state stays IDLE, busy stays 0, and done pulses in the next cycle. div_zero is unchanged.
- Start accepted at edge T (MULTU/DIVU):
  - Load opnd, set cnt=0, enter RUN.
  - RUN covers cycles T+1 to T+32, with busy=1.
  - DONE is cycle T+33: done=1, busy=1, final hi/lo visible.
  - Back in IDLE at T+34. Latency is 33 cycles from the start edge to done.
- start while busy=1 is ignored, with no side effects.
- MULTU:
  - Init: hi=0, lo=rt, opnd=rs, div_zero=0.
  - Each RUN cycle: alu_a=hi, alu_b=opnd, alu_ctrl=0010.
  - If lo[0]=1: s=alu_result and c=(alu_result < hi, unsigned). Otherwise s=hi and c=0.
  - Update {hi,lo} = {c, s, lo[31:1]}.
  - After 32 iterations, {hi,lo} = rs*rt (64-bit unsigned).
- DIVU (restoring):
  - Init: hi=0, lo=rs, opnd=rt, div_zero=(rt==0).
  - Each RUN cycle: r={hi[30:0],lo[31]} and b=hi[31]. Drive alu_a=r, alu_b=opnd, alu_ctrl=0110.
  - If b or r>=opnd (unsigned): hi=alu_result and lo={lo[30:0],1}. Otherwise hi=r and lo={lo[30:0],0}.
  - Result: lo=quotient, hi=remainder.
  - Divide by zero needs no special path and naturally yields lo=FFFFFFFF, hi=rs. div_zero=1 flags it.
- IDLE and DONE drive alu_a=0, alu_b=0, alu_ctrl=0010.
- The block never reads ALU zero. Carry and borrow are derived locally as above.
- hi and lo change only at a reset, a RUN edge, an MTHI/MTLO edge, or a MULTU/DIVU init edge.

Decomposition:
- Shared package holds:
  - MD_MULTU, MD_DIVU, MD_MTHI, MD_MTLO opcodes (2 bits).
  - ALU_ADD=4'b0010 and ALU_SUB=4'b0110, shared with the ALU decoder.
  - State encoding: IDLE, RUN, DONE.
- No sub-module; this is a single FSM plus datapath registers. The ALU is instantiated at the top level, with a mux so EX owns it when busy=0.

Test Plan:
- MULTU rs=7, rt=6, start at T: busy 1 during T+1 to T+33; done=1 at T+33 only; hi=0, lo=0x2A; busy=0 at T+34.
- MULTU rs=rt=FFFFFFFF: hi=FFFFFFFE, lo=00000001. Also check the carry path every cycle.
- DIVU rs=100, rt=7: lo=14, hi=2, div_zero=0. Also DIVU rs=FFFFFFFF, rt=1: lo=FFFFFFFF, hi=0.
- DIVU rs=80000000, rt=0: done at T+33, div_zero=1, lo=FFFFFFFF, hi=80000000. A following MULTU clears div_zero at its start edge.
- Start MULTU, pulse rst in RUN cycle 10: next cycle state IDLE, busy=0, done=0, hi=lo=0, and done never pulses.
- MTHI rs=DEADBEEF in IDLE: hi=DEADBEEF next cycle, done pulse, busy stays 0. Then start DIVU, and drive start with op=MTLO while busy: ignored, and lo is not written by it.
